// File: rtl/clock_pkg.sv
// Shared calendar constants, FSM state type and leap-year rule for the
// date/time to Unix-seconds conversion path.
package clock_pkg;

  localparam int YEAR_MIN      = 1970;
  localparam int YEAR_MAX      = 2099;
  localparam int SECS_PER_DAY  = 86400;
  localparam int SECS_PER_HOUR = 3600;
  localparam int SECS_PER_MIN  = 60;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    YEARS,
    MONTHS,
    FINISH,
    LOAD
  } state_t;

  // Within 1970..2099 the century exceptions never apply, so year%4 suffices.
  function automatic logic is_leap(input logic [11:0] y);
    return (y[1:0] == 2'd0);
  endfunction

endpackage

// File: rtl/days_in_month.sv
// Combinational month-length lookup; returns 0 for an illegal month so a
// day comparison against it always fails.
module days_in_month (
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] len
);

  always_comb begin
    // NOTE: every path assigns len (default arm included), so no latch is inferred.
    case (month)
      4'd2:                                    len = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:                 len = 5'd30;
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10,
      4'd12:                                   len = 5'd31;
      default:                                 len = 5'd0;
    endcase
  end

endmodule

// File: rtl/datetime_to_unix.sv
// Iterative calendar-to-Unix-seconds converter: accumulates one year or month
// per clock, then loads the result into the Unix counter with a load_n pulse.
module datetime_to_unix #(
  parameter int YEAR_MIN = clock_pkg::YEAR_MIN,
  parameter int YEAR_MAX = clock_pkg::YEAR_MAX,
  parameter int CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [11:0]      year,
  input  logic [3:0]       month,
  input  logic [4:0]       day,
  input  logic [4:0]       hour,
  input  logic [5:0]       minute,
  input  logic [5:0]       second,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] set_counter,
  output logic             load_n
);

  import clock_pkg::*;

  localparam logic [11:0] Y_MIN = 12'(YEAR_MIN);
  localparam logic [11:0] Y_MAX = 12'(YEAR_MAX);
  localparam int          SEC_W = 34;

  state_t      state, state_next;

  logic [11:0] year_q;
  logic [3:0]  month_q;
  logic [4:0]  day_q;
  logic [4:0]  hour_q;
  logic [5:0]  minute_q;
  logic [5:0]  second_q;

  logic [11:0] yr_idx;
  logic [3:0]  mo_idx;
  logic [15:0] day_acc;
  logic        err_q;

  logic [3:0]  dim_month;
  logic [4:0]  dim_len;
  logic        fields_ok;
  logic [15:0] days_total;
  logic [SEC_W-1:0] total_secs;

  // One lookup serves both day validation (CHECK) and month accumulation (MONTHS).
  assign dim_month = (state == MONTHS) ? mo_idx : month_q;

  days_in_month u_dim (
    .month (dim_month),
    .leap  (is_leap(year_q)),
    .len   (dim_len)
  );

  always_comb begin
    fields_ok = (year_q >= Y_MIN) && (year_q <= Y_MAX)
             && (month_q != 4'd0) && (month_q <= 4'd12)
             && (day_q != 5'd0) && (day_q <= dim_len)
             && (hour_q <= 5'd23)
             && (minute_q <= 6'd59) && (second_q <= 6'd59);
  end

  always_comb begin
    days_total = day_acc + 16'(day_q) - 16'd1;
    total_secs = SEC_W'(days_total) * SEC_W'(SECS_PER_DAY)
               + SEC_W'(hour_q)     * SEC_W'(SECS_PER_HOUR)
               + SEC_W'(minute_q)   * SEC_W'(SECS_PER_MIN)
               + SEC_W'(second_q);
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = fields_ok ? YEARS : IDLE;
      YEARS:   if (yr_idx == year_q) state_next = MONTHS;
      MONTHS:  if (mo_idx == month_q) state_next = FINISH;
      FINISH:  state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs; err_q carries the CHECK verdict into the following IDLE cycle.
  always_comb begin
    busy   = (state != IDLE);
    load_n = (state != LOAD);
    done   = (state == LOAD) || err_q;
    err    = err_q;
  end

  // Datapath: field capture, accumulators and the result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      year_q      <= '0;
      month_q     <= '0;
      day_q       <= '0;
      hour_q      <= '0;
      minute_q    <= '0;
      second_q    <= '0;
      yr_idx      <= '0;
      mo_idx      <= '0;
      day_acc     <= '0;
      err_q       <= 1'b0;
      set_counter <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          year_q   <= year;
          month_q  <= month;
          day_q    <= day;
          hour_q   <= hour;
          minute_q <= minute;
          second_q <= second;
        end
        CHECK: begin
          err_q   <= !fields_ok;
          yr_idx  <= Y_MIN;
          day_acc <= '0;
        end
        YEARS: begin
          if (yr_idx != year_q) begin
            day_acc <= day_acc + (is_leap(yr_idx) ? 16'd366 : 16'd365);
            yr_idx  <= yr_idx + 12'd1;
          end else begin
            mo_idx <= 4'd1;
          end
        end
        MONTHS: if (mo_idx != month_q) begin
          day_acc <= day_acc + 16'(dim_len);
          mo_idx  <= mo_idx + 4'd1;
        end
        FINISH: set_counter <= CNT_W'(total_secs);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datetime_to_unix.sv
// Self-checking bench for datetime_to_unix: table-driven vectors scored through
// an expectation queue, plus hand sequences for busy-start and mid-run reset.
module tb_datetime_to_unix;

  localparam int CNT_W = 64;

  typedef struct {
    logic [11:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [4:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    bit          exp_err;
    logic [63:0] exp_cnt;
  } vec_t;

  typedef struct {
    bit          err;
    logic [63:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [11:0]      year = '0;
  logic [3:0]       month = '0;
  logic [4:0]       day = '0;
  logic [4:0]       hour = '0;
  logic [5:0]       minute = '0;
  logic [5:0]       second = '0;
  logic             busy, done, err, load_n;
  logic [CNT_W-1:0] set_counter;

  always #5 clk = ~clk;

  datetime_to_unix #(.YEAR_MIN(1970), .YEAR_MAX(2099), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .year        (year),
    .month       (month),
    .day         (day),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .set_counter (set_counter),
    .load_n      (load_n)
  );

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_loads = 0;
  logic [63:0] last_valid = '0;
  vec_t        tbl[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int y, input int mo, input int d, input int h,
                              input int mi, input int s, input bit e, input logic [63:0] c);
    vec_t v;
    v.year = 12'(y);  v.month = 4'(mo); v.day = 5'(d);
    v.hour = 5'(h);   v.minute = 6'(mi); v.second = 6'(s);
    v.exp_err = e;    v.exp_cnt = c;
    return v;
  endfunction

  // Closed-form reference: leap count by division plus a cumulative month table.
  function automatic logic [63:0] model(input vec_t v);
    int     cum[12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
    int     y = int'(v.year);
    int     mo = int'(v.month);
    longint d;
    d = longint'(365 * (y - 1970) + (y - 1969) / 4 + cum[mo - 1]
                 + (((y % 4) == 0 && mo > 2) ? 1 : 0) + int'(v.day) - 1);
    return 64'(d * 86400 + longint'(v.hour) * 3600 + longint'(v.minute) * 60
               + longint'(v.second));
  endfunction

  // Scoreboard monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (!load_n) n_loads++;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("err", err, mon_e.err);
        check("load_n", load_n, mon_e.err);
        check("set_counter", set_counter, mon_e.cnt);
      end
    end else if (rst_n && !load_n) begin
      check("load_without_done", load_n, 1'b1);
    end
  end

  task automatic drive_fields(input vec_t v);
    year = v.year; month = v.month; day = v.day;
    hour = v.hour; minute = v.minute; second = v.second;
  endtask

  task automatic run_conv(input vec_t v, input bit poke);
    exp_t e;
    int   k;
    int   lat;
    int   loads0;
    bit   busy_ok;
    e.err = v.exp_err;
    e.cnt = v.exp_err ? last_valid : v.exp_cnt;
    if (!v.exp_err) last_valid = v.exp_cnt;
    lat = v.exp_err ? 1 : (int'(v.year) - 1970) + int'(v.month) + 3;
    @(negedge clk);
    drive_fields(v);
    start = 1'b1;
    sb.push_back(e);
    loads0 = n_loads;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!done && k < 400) begin
      if (!busy) busy_ok = 1'b0;
      if (poke && k == 3) begin
        drive_fields(mk(1970, 1, 1, 0, 0, 0, 1'b0, 64'd0));
        start = 1'b1;
      end
      if (poke && k == 4) start = 1'b0;
      @(negedge clk);
      k++;
    end
    if (!done) begin
      check("timeout", done, 1'b1);
    end else begin
      check("latency", 64'(k), 64'(lat));
      check("busy_at_done", busy, !v.exp_err);
    end
    check("busy_during", busy_ok, 1'b1);
    @(negedge clk);
    check("busy_after", busy, 1'b0);
    check("done_width", done, 1'b0);
    check("load_pulses", 64'(n_loads - loads0), v.exp_err ? 64'd0 : 64'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0]  = mk(1970,  1,  1,  0,  0,  0, 1'b0, 64'd0);
    tbl[1]  = mk(2000,  2, 29, 12, 34, 56, 1'b0, 64'd951827696);
    tbl[2]  = mk(2099, 12, 31, 23, 59, 59, 1'b0, 64'd4102444799);
    tbl[3]  = mk(2001,  2, 29,  0,  0,  0, 1'b1, 64'd0);
    tbl[4]  = mk(2010, 13,  1,  0,  0,  0, 1'b1, 64'd0);
    tbl[5]  = mk(2010,  6,  1, 24,  0,  0, 1'b1, 64'd0);
    tbl[6]  = mk(1972,  3,  1,  0,  0,  0, 1'b0, 64'd68256000);
    tbl[7]  = mk(2038,  1, 19,  3, 14,  7, 1'b0, 64'd2147483647);
    tbl[8]  = mk(1999, 12, 31, 23, 59, 59, 1'b0, 64'd946684799);
    tbl[9]  = mk(2024,  2, 29, 23, 59, 59, 1'b0, 64'd1709251199);
    tbl[10] = mk(2010,  5,  0,  0,  0,  0, 1'b1, 64'd0);
    tbl[11] = mk(2000,  4, 31,  0,  0,  0, 1'b1, 64'd0);
    tbl[12] = mk(1969, 12, 31, 23, 59, 59, 1'b1, 64'd0);
    tbl[13] = mk(2100,  1,  1,  0,  0,  0, 1'b1, 64'd0);
    tbl[14] = mk(2020,  7,  4, 12, 60,  0, 1'b1, 64'd0);
    tbl[15] = mk(2020,  7,  4, 12,  0, 60, 1'b1, 64'd0);
    tbl[16] = mk(1971,  2, 29,  0,  0,  0, 1'b1, 64'd0);
    tbl[17] = mk(2000,  0,  1,  0,  0,  0, 1'b1, 64'd0);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_load_n", load_n, 1'b1);
    check("rst_set_counter", set_counter, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_conv(tbl[i], 1'b0);

    for (int i = 0; i < 4; i++) begin
      v = mk(int'($urandom_range(2099, 1970)), int'($urandom_range(12, 1)),
             int'($urandom_range(28, 1)), int'($urandom_range(23, 0)),
             int'($urandom_range(59, 0)), int'($urandom_range(59, 0)), 1'b0, 64'd0);
      v.exp_cnt = model(v);
      run_conv(v, 1'b0);
    end

    // start and field changes while busy must not disturb the latched request
    run_conv(mk(2000, 2, 29, 12, 34, 56, 1'b0, 64'd951827696), 1'b1);

    // Reset during YEARS of a long conversion
    @(negedge clk);
    drive_fields(tbl[2]);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy_before_rst", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_load_n", load_n, 1'b1);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_set_counter", set_counter, 64'd0);
    rst_n = 1'b1;
    last_valid = 64'd0;
    run_conv(tbl[0], 1'b0);
    run_conv(tbl[6], 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
